dac_serial_tx: RTL
==================

// Module: dac_serial_tx
// PURPOSE
//  Parallel-to-serial transmitter for the output DAC path. It reads a held sample
//  word (e.g. from a Reg_n output), latches it on EN and shifts it out MSB-first.
//  The serial frame is SYNC_n/SCLK/SDO (SPI mode: SCLK idles low, DAC samples on
//  the SCLK rising edge). Sits between the filter output register and the DAC pins.
//  Busy/done let the control FSM pace one sample per frame.
// PARAMETERS
//  size     12  sample width in bits = bits per frame (legal: >= 2)
//  CLK_DIV  2   clk cycles per SCLK half-period (legal: >= 1); SCLK = clk/(2*CLK_DIV)
// PORTS
//  clk     in   1     system clock; all logic on posedge clk
//  rst     in   1     synchronous, active-high reset
//  EN      in   1     start request; accepted only in IDLE
//  In      in   size  sample word; sampled only on the accept cycle
//  sync_n  out  1     frame select to DAC, active low
//  sclk    out  1     serial clock to DAC
//  sdo     out  1     serial data to DAC, MSB first
//  busy    out  1     high from the cycle after accept through the DONE cycle
//  done    out  1     one-cycle pulse at end of frame
// BEHAVIOUR
//  - One clock domain. Reset is synchronous and active-high. All outputs are registered.
//  - Reset values: sync_n=1, sclk=0, sdo=0, busy=0, done=0, state=IDLE, counters=0.
//    rst=1 on any edge, including mid-frame, returns to these values at that edge.
//    The partial frame is abandoned; no done pulse is produced.
//  - FSM: IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE: if EN=1, at the edge do:
//      shreg<=In, bit_cnt<=size-1, div_cnt<=0,
//      sync_n<=0, sdo<=In[size-1], busy<=1, state<=SHIFT.
//    If EN=0, all outputs hold their reset values.
//  - SHIFT: div_cnt counts 0..CLK_DIV-1 and wraps. A tick occurs when div_cnt==CLK_DIV-1.
//    On each tick sclk toggles.
//      - 0->1 tick: rising edge; the DAC samples sdo. sdo is stable for CLK_DIV cycles
//        before and after this edge.
//      - 1->0 tick, bit_cnt!=0: shift shreg left; sdo<=next bit; bit_cnt--.
//      - 1->0 tick, bit_cnt==0: sync_n<=1, sdo<=0, done<=1, state<=DONE.
//  - SHIFT lasts exactly size*2*CLK_DIV cycles, so sync_n is low for exactly that long.
//    The first SCLK rise comes CLK_DIV cycles after sync_n falls.
//    Exactly size rising edges occur per frame.
//  - DONE: lasts one cycle with done=1 and busy=1. At the next edge: done<=0, busy<=0,
//    state<=IDLE.
//  - EN is ignored in SHIFT and DONE; there is no queuing.
//    With EN held high, back-to-back frames run with sync_n high for exactly 2 cycles
//    (DONE + IDLE).
//  - Changes on In after the accept cycle do not affect the frame in flight.
// TESTING
//  1 rst=1 for 3 cycles, EN=0 -> sync_n=1, sclk=0, sdo=0, busy=0, done=0 every cycle.
//  2 size=12, CLK_DIV=2, In=12'hA5C, EN pulse 1 cycle -> sync_n low 48 cycles.
//    The 12 SCLK rising edges sample 1010_0101_1100. done=1 for 1 cycle right after,
//    then busy=0.
//  3 Same frame, In changed to 12'h000 and EN re-pulsed mid-frame -> frame still
//    carries A5C; no second frame starts; single done pulse.
//  4 EN held high, In=12'hFFF then 12'h001 -> two frames; sync_n high exactly 2 cycles
//    between them. Second frame shifts 0000_0000_0001.
//  5 rst=1 after the 5th SCLK rise -> next edge gives sync_n=1, sclk=0, busy=0, no done.
//    A new EN then yields a full 12-bit frame.
//  6 CLK_DIV=1, In=12'h801 -> sclk toggles every clk; sync_n low 24 cycles;
//    bits 1000_0000_0001.

Source files
------------

// File: rtl/dac_serial_tx.sv
// Parallel-to-serial DAC transmitter. It latches a sample word on EN and shifts it
// out MSB-first on SYNC_n/SCLK/SDO. SCLK idles low and the DAC samples on the SCLK rising edge.
module dac_serial_tx #(
    parameter int size    = 12,
    parameter int CLK_DIV = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            EN,
    input  logic [size-1:0] In,
    output logic            sync_n,
    output logic            sclk,
    output logic            sdo,
    output logic            busy,
    output logic            done,
    output logic [1:0]      fsm_state
);

    localparam int CNT_W = (size > 1) ? $clog2(size) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(size - 1);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [size-1:0]   shreg, shreg_d;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_d;
    logic [DIV_W-1:0]  div_cnt, div_cnt_d;
    logic              sync_n_d, sclk_d, sdo_d, busy_d, done_d;
    logic              tick;

    assign fsm_state = state;
    assign tick      = (div_cnt == DIV_MAX);

    // Handshake: EN is a request that is taken only while IDLE (busy=0).
    // busy stays high from the cycle after acceptance through the done pulse.
    // EN is ignored while busy is high, and no request is queued.
    always_comb begin
        state_d   = state;
        shreg_d   = shreg;
        bit_cnt_d = bit_cnt;
        div_cnt_d = div_cnt;
        sync_n_d  = sync_n;
        sclk_d    = sclk;
        sdo_d     = sdo;
        busy_d    = busy;
        done_d    = done;
        unique case (state)
            IDLE: begin
                if (EN) begin
                    shreg_d   = In;
                    bit_cnt_d = LAST_BIT;
                    div_cnt_d = '0;
                    sync_n_d  = 1'b0;
                    sdo_d     = In[size-1];
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                div_cnt_d = tick ? '0 : div_cnt + DIV_W'(1);
                if (tick) begin
                    sclk_d = ~sclk;
                    // Data changes only on the falling tick, so sdo is centred on the rising edge.
                    if (sclk) begin
                        if (bit_cnt != '0) begin
                            shreg_d   = shreg << 1;
                            sdo_d     = shreg[size-2];
                            bit_cnt_d = bit_cnt - CNT_W'(1);
                        end else begin
                            sync_n_d = 1'b1;
                            sdo_d    = 1'b0;
                            done_d   = 1'b1;
                            state_d  = DONE;
                        end
                    end
                end
            end
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            sync_n  <= 1'b1;
            sclk    <= 1'b0;
            sdo     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            shreg   <= shreg_d;
            bit_cnt <= bit_cnt_d;
            div_cnt <= div_cnt_d;
            sync_n  <= sync_n_d;
            sclk    <= sclk_d;
            sdo     <= sdo_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule
